// File: rtl/cdb_arbiter.sv
// Writeback CDB arbiter: per-FU one-entry holding registers feed a round-robin
// selector whose winner is broadcast through a registered CDB output.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ROB_IDX = 5,
  parameter int PRF_IDX = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ROB_IDX-1:0] req_rob_id,
  input  logic [NUM_REQ*PRF_IDX-1:0] req_rd_phy,
  input  logic [NUM_REQ*5-1:0]       req_rd_arch,
  input  logic [NUM_REQ*32-1:0]      req_rd_value,
  output logic                       cdb_valid,
  output logic [ROB_IDX-1:0]         cdb_rob_id,
  output logic [PRF_IDX-1:0]         cdb_rd_phy,
  output logic [4:0]                 cdb_rd_arch,
  output logic [31:0]                cdb_rd_value
);

  localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] held;
  logic [NUM_REQ-1:0] grant;
  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   rr_ptr_reg;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [PTR_W:0]     scan_sum;

  logic [ROB_IDX-1:0] ent_rob   [NUM_REQ];
  logic [PRF_IDX-1:0] ent_phy   [NUM_REQ];
  logic [4:0]         ent_arch  [NUM_REQ];
  logic [31:0]        ent_value [NUM_REQ];

  // Per-requester holding register; a grant in the same cycle frees the slot
  // so a sole requester can sustain one result per cycle.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_entry
    logic               held_reg;
    logic [ROB_IDX-1:0] rob_reg;
    logic [PRF_IDX-1:0] phy_reg;
    logic [4:0]         arch_reg;
    logic [31:0]        value_reg;
    logic               accept;

    assign req_ready[gi] = !flush && (!held_reg || grant[gi]);
    assign accept        = req_valid[gi] && req_ready[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        held_reg  <= 1'b0;
        rob_reg   <= '0;
        phy_reg   <= '0;
        arch_reg  <= '0;
        value_reg <= '0;
      end else if (flush) begin
        held_reg <= 1'b0;
      end else if (accept) begin
        held_reg  <= 1'b1;
        rob_reg   <= req_rob_id[gi*ROB_IDX +: ROB_IDX];
        phy_reg   <= req_rd_phy[gi*PRF_IDX +: PRF_IDX];
        arch_reg  <= req_rd_arch[gi*5 +: 5];
        value_reg <= req_rd_value[gi*32 +: 32];
      end else if (grant[gi]) begin
        held_reg <= 1'b0;
      end
    end

    assign held[gi]      = held_reg;
    assign ent_rob[gi]   = rob_reg;
    assign ent_phy[gi]   = phy_reg;
    assign ent_arch[gi]  = arch_reg;
    assign ent_value[gi] = value_reg;
  end

  // Round-robin scan starting at rr_ptr with explicit modulo wrap, so any
  // NUM_REQ in range works without a power-of-two pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(off);
      if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
      end
      if (!grant_found && held[scan_sum[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_sum[PTR_W-1:0];
      end
    end
    if (flush) begin
      grant_found = 1'b0;
    end
  end

  always_comb begin
    grant = '0;
    if (grant_found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
      rr_ptr_next = '0;
    end else begin
      rr_ptr_next = grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (grant_found) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Data fields keep their last value when idle; only cdb_valid qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid    <= 1'b0;
      cdb_rob_id   <= '0;
      cdb_rd_phy   <= '0;
      cdb_rd_arch  <= '0;
      cdb_rd_value <= '0;
    end else begin
      cdb_valid <= grant_found;
      if (grant_found) begin
        cdb_rob_id   <= ent_rob[grant_idx];
        cdb_rd_phy   <= ent_phy[grant_idx];
        cdb_rd_arch  <= ent_arch[grant_idx];
        cdb_rd_value <= ent_value[grant_idx];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: single result, contention, fairness,
// backpressure, flush and pointer wrap, with hand-computed CDB contents.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int RB = 5;
  localparam int PB = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*RB-1:0] req_rob_id;
  logic [N*PB-1:0] req_rd_phy;
  logic [N*5-1:0]  req_rd_arch;
  logic [N*32-1:0] req_rd_value;
  logic            cdb_valid;
  logic [RB-1:0]   cdb_rob_id;
  logic [PB-1:0]   cdb_rd_phy;
  logic [4:0]      cdb_rd_arch;
  logic [31:0]     cdb_rd_value;

  logic        tb_valid [N];
  logic [4:0]  tb_rob   [N];
  logic [5:0]  tb_phy   [N];
  logic [4:0]  tb_arch  [N];
  logic [31:0] tb_val   [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_valid    = '0;
    req_rob_id   = '0;
    req_rd_phy   = '0;
    req_rd_arch  = '0;
    req_rd_value = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = tb_valid[i];
      req_rob_id[i*RB +: RB] = tb_rob[i];
      req_rd_phy[i*PB +: PB] = tb_phy[i];
      req_rd_arch[i*5 +: 5]  = tb_arch[i];
      req_rd_value[i*32 +: 32] = tb_val[i];
    end
  end

  cdb_arbiter #(.NUM_REQ(N), .ROB_IDX(RB), .PRF_IDX(PB)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rob_id   (req_rob_id),
    .req_rd_phy   (req_rd_phy),
    .req_rd_arch  (req_rd_arch),
    .req_rd_value (req_rd_value),
    .cdb_valid    (cdb_valid),
    .cdb_rob_id   (cdb_rob_id),
    .cdb_rd_phy   (cdb_rd_phy),
    .cdb_rd_arch  (cdb_rd_arch),
    .cdb_rd_value (cdb_rd_value)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) tb_valid[i] = 1'b0;
  endtask

  // Derived fields make every broadcast field traceable to its rob id.
  task automatic present(input int i, input logic [4:0] rob);
    tb_valid[i] = 1'b1;
    tb_rob[i]   = rob;
    tb_phy[i]   = 6'(rob) + 6'd16;
    tb_arch[i]  = rob ^ 5'h1f;
    tb_val[i]   = 32'h1000_0000 | 32'(rob);
  endtask

  task automatic expect_cdb(input string tag, input logic [4:0] rob);
    check({tag, ".valid"}, 64'(cdb_valid), 64'd1);
    check({tag, ".rob"}, 64'(cdb_rob_id), 64'(rob));
    check({tag, ".phy"}, 64'(cdb_rd_phy), 64'(6'(rob) + 6'd16));
    check({tag, ".arch"}, 64'(cdb_rd_arch), 64'(rob ^ 5'h1f));
    check({tag, ".value"}, 64'(cdb_rd_value), 64'(32'h1000_0000 | 32'(rob)));
    $display("%s: cdb valid=%0b rob=%0d phy=%0d value=%08h", tag, cdb_valid, cdb_rob_id,
             cdb_rd_phy, cdb_rd_value);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".idle"}, 64'(cdb_valid), 64'd0);
    $display("%s: cdb valid=%0b", tag, cdb_valid);
  endtask

  task automatic check_ready(input string tag, input logic [N-1:0] exp);
    #1;
    check({tag, ".ready"}, 64'(req_ready), 64'(exp));
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    flush = 1'b0;
    idle_all();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      tb_valid[i] = 1'b0;
      tb_rob[i]   = '0;
      tb_phy[i]   = '0;
      tb_arch[i]  = '0;
      tb_val[i]   = '0;
    end
    rst   = 1'b1;
    flush = 1'b0;

    // Reset state and a single result from FU1
    do_reset();
    check("rst.valid", 64'(cdb_valid), 64'd0);
    check("rst.rob", 64'(cdb_rob_id), 64'd0);
    check("rst.phy", 64'(cdb_rd_phy), 64'd0);
    check("rst.value", 64'(cdb_rd_value), 64'd0);
    check_ready("rst", 4'hF);
    tb_valid[1] = 1'b1; tb_rob[1] = 5'd3; tb_phy[1] = 6'd9;
    tb_arch[1] = 5'd7;  tb_val[1] = 32'hDEADBEEF;
    check_ready("single.c0", 4'hF);
    step();
    idle_all();
    expect_idle("single.c1");
    step();
    check("single.c2.valid", 64'(cdb_valid), 64'd1);
    check("single.c2.rob", 64'(cdb_rob_id), 64'd3);
    check("single.c2.phy", 64'(cdb_rd_phy), 64'd9);
    check("single.c2.arch", 64'(cdb_rd_arch), 64'd7);
    check("single.c2.value", 64'(cdb_rd_value), 64'hDEADBEEF);
    $display("single.c2: cdb valid=%0b rob=%0d value=%08h", cdb_valid, cdb_rob_id, cdb_rd_value);
    step();
    expect_idle("single.c3");

    // Full contention from rr_ptr=0
    do_reset();
    for (int i = 0; i < N; i++) present(i, 5'(4 + i));
    check_ready("full.c0", 4'hF);
    step();
    idle_all();
    expect_idle("full.c1");
    check_ready("full.c1", 4'b0001);
    step();
    expect_cdb("full.c2", 5'd4);
    step();
    expect_cdb("full.c3", 5'd5);
    step();
    expect_cdb("full.c4", 5'd6);
    step();
    expect_cdb("full.c5", 5'd7);
    step();
    expect_idle("full.c6");

    // Fairness: FU0 sustained, FU2 once (rr_ptr=0)
    present(0, 5'd10);
    present(2, 5'd20);
    check_ready("fair.c0", 4'hF);
    step();
    tb_valid[2] = 1'b0;
    present(0, 5'd11);
    expect_idle("fair.c1");
    check_ready("fair.c1", 4'b1011);
    step();
    present(0, 5'd12);
    expect_cdb("fair.c2", 5'd10);
    check_ready("fair.c2", 4'b1110);
    step();
    expect_cdb("fair.c3", 5'd20);
    check_ready("fair.c3", 4'hF);
    step();
    present(0, 5'd13);
    expect_cdb("fair.c4", 5'd11);
    check_ready("fair.c4", 4'hF);
    step();
    tb_valid[0] = 1'b0;
    expect_cdb("fair.c5", 5'd12);
    step();
    expect_cdb("fair.c6", 5'd13);
    step();
    expect_idle("fair.c7");

    // Backpressure on FU3 (rr_ptr=1)
    present(1, 5'd21);
    present(3, 5'd23);
    check_ready("bp.c0", 4'hF);
    step();
    tb_valid[1] = 1'b0;
    present(3, 5'd24);
    expect_idle("bp.c1");
    check_ready("bp.c1", 4'b0111);
    step();
    expect_cdb("bp.c2", 5'd21);
    check_ready("bp.c2", 4'hF);
    step();
    tb_valid[3] = 1'b0;
    expect_cdb("bp.c3", 5'd23);
    step();
    expect_cdb("bp.c4", 5'd24);
    step();
    expect_idle("bp.c5");

    // Flush with FU2/FU3 still held (rr_ptr=0)
    present(1, 5'd25);
    present(2, 5'd26);
    present(3, 5'd27);
    step();
    idle_all();
    expect_idle("flush.c1");
    step();
    flush = 1'b1;
    present(0, 5'd28);
    expect_cdb("flush.c2", 5'd25);
    check_ready("flush.c2", 4'h0);
    step();
    flush = 1'b0;
    present(0, 5'd29);
    expect_idle("flush.c3");
    check_ready("flush.c3", 4'hF);
    step();
    idle_all();
    expect_idle("flush.c4");
    step();
    expect_cdb("flush.c5", 5'd29);
    step();
    expect_idle("flush.c6");

    // Wrap-around: drive rr_ptr to 3, then FU0 and FU3 held together
    present(2, 5'd30);
    step();
    idle_all();
    expect_idle("wrap.c1");
    step();
    expect_cdb("wrap.c2", 5'd30);
    present(0, 5'd1);
    present(3, 5'd31);
    step();
    idle_all();
    expect_idle("wrap.c3");
    step();
    expect_cdb("wrap.c4", 5'd31);
    step();
    expect_cdb("wrap.c5", 5'd1);
    present(0, 5'd2);
    present(1, 5'd9);
    step();
    idle_all();
    expect_idle("wrap.c6");
    step();
    expect_cdb("wrap.c7", 5'd9);
    step();
    expect_cdb("wrap.c8", 5'd2);
    step();
    expect_idle("wrap.c9");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
